// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, oversampling
// constants and the baud divider calculation.
// Build option: UART_RX_PARITY_EN adds the parity state (8E1 framing).
package uart_pkg;

  // Oversample ticks per bit and the three majority-vote sample points.
  localparam int unsigned OVERSAMPLE    = 16;
  localparam logic [3:0]  SAMPLE_TICK_0 = 4'd7;
  localparam logic [3:0]  SAMPLE_TICK_1 = 4'd8;
  localparam logic [3:0]  SAMPLE_TICK_2 = 4'd9;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3
`ifdef UART_RX_PARITY_EN
    , StParity = 3'd4
`endif
  } uart_rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + 8 * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with occupancy count; head data read straight from storage
// flops. Simultaneous push and pop on a full FIFO both succeed.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_en;
  logic             pop_en;

  assign full    = (level_q == LvlFull);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, 16x oversampling, 3-sample majority vote,
// framing FSM and receive FIFO with valid/ready output.
// Build option: UART_RX_PARITY_EN selects 8E1 framing with parity checking;
// otherwise 8N1 and parity_err is tied low.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

  uart_rx_state_e state_q, state_d;

  logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic            fall;
  logic [DivW-1:0] div_cnt_q;
  logic            tick;
  logic [3:0]      tick_cnt_q;
  logic [3:0]      tick_num;
  logic            tick_s0, tick_s1, decide;
  logic            samp0_q, samp1_q;
  logic            maj;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            wait_high_q, wait_high_d;
  logic            push_req_q, push_req_d;
  logic            frame_q, frame_d;
  logic            fifo_full, fifo_empty;
  logic            pop;

`ifdef UART_RX_PARITY_EN
  logic            perr_pend_q, perr_pend_d;
  logic            perr_q, perr_d;
`endif

  // Two-flop synchroniser plus edge-detect history, all idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign fall = rxd_prev_q && !rxd_sync_q;

  // Oversample tick divider; held at zero in idle so ticks align to the start edge.
  always_ff @(posedge clk) begin
    if (rst || state_q == StIdle) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == DivMax) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  assign tick = (state_q != StIdle) && (div_cnt_q == DivMax);

  // Tick position within the current bit; wraps every 16 ticks.
  always_ff @(posedge clk) begin
    if (rst || state_q == StIdle) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= tick_cnt_q + 4'd1;
    end
  end

  // tick_num is the index of the tick firing now (first tick after the edge is 1).
  assign tick_num = tick_cnt_q + 4'd1;
  assign tick_s0  = tick && (tick_num == SAMPLE_TICK_0);
  assign tick_s1  = tick && (tick_num == SAMPLE_TICK_1);
  assign decide   = tick && (tick_num == SAMPLE_TICK_2);

  // Capture the first two votes; the third is the live synchronised value.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp0_q <= 1'b1;
      samp1_q <= 1'b1;
    end else begin
      if (tick_s0) samp0_q <= rxd_sync_q;
      if (tick_s1) samp1_q <= rxd_sync_q;
    end
  end

  assign maj = (samp0_q & samp1_q) | (samp0_q & rxd_sync_q) | (samp1_q & rxd_sync_q);

  // FSM and datapath state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
      push_req_q  <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
      push_req_q  <= push_req_d;
      frame_q     <= frame_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity result is held from the parity bit until the stop bit is judged.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
    end
  end
`endif

  // Next-state logic: framing decisions are made once per bit at the third vote.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;
    push_req_d  = 1'b0;
    frame_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_pend_d = perr_pend_q;
    perr_d      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d     = StStart;
          bit_idx_d   = '0;
          wait_high_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_pend_d = 1'b0;
`endif
        end
      end
      StStart: begin
        // A start bit that votes high was a glitch; drop it silently.
        if (decide) begin
          state_d = maj ? StIdle : StData;
        end
      end
      StData: begin
        if (decide) begin
          shift_d   = {maj, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (decide) begin
          perr_pend_d = maj ^ (^shift_q);
          state_d     = StStop;
        end
      end
`endif
      StStop: begin
        if (wait_high_q) begin
          // Hold off after a framing error until the line idles, so a break
          // is not taken as a new start bit.
          if (rxd_sync_q) begin
            state_d     = StIdle;
            wait_high_d = 1'b0;
          end
        end else if (decide) begin
          if (maj) begin
            push_req_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d     = perr_pend_q;
`endif
            state_d    = StIdle;
          end else begin
            frame_d     = 1'b1;
            wait_high_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = rx_valid && rx_ready;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req_q),
    .push_data (shift_q),
    .pop       (pop),
    .rd_data   (rx_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid  = !fifo_empty;
  assign rx_busy   = (state_q != StIdle);
  assign frame_err = frame_q;
  // A concurrent pop makes room, so only a push into a full, non-draining FIFO drops.
  assign overrun   = push_req_q && fifo_full && !pop;

`ifdef UART_RX_PARITY_EN
  // Overrun wins when a bad-parity byte is also dropped, keeping pulses exclusive.
  assign parity_err = perr_q && !overrun;
`else
  assign parity_err = 1'b0;
`endif

endmodule
